vend_checkout_core: RTL and testbench
=====================================

# vend_checkout_core

Parametrised vending checkout controller: debounces N coin keys and a confirm key, accumulates paid and cart totals in saturating binary, and accepts armed item-select / clear commands from the voice decoder. It computes live change, runs a SHOP → VEND → CHANGE checkout sequence that drives the dispenser servo enable, and presents all three totals as packed BCD for the downstream seven-segment encoders.

## Interface
- NKEY, 2: number of coin keys (1..8)
- COIN_VALS, {8'd1,8'd5}: packed coin values; key i value at [8i+7:8i]
- NITEM, 4: number of items (1..6)
- PRICES, {8'd10,8'd8,8'd5,8'd3}: packed prices; item i (code i+1) at [8i+7:8i]
- DIGITS, 2: BCD digits per display; MAXVAL = 10^DIGITS−1; internal total width TW = clog2(MAXVAL+1)
- DEBOUNCE, 8: stable cycles required on a key (≥2)
- VEND_CYCLES, 16: vend_en high time
- HOLD_CYCLES, 32: change hold time after vend
- ARM_CODE, 3'b111: command that arms the select logic
---
- clock  in  1  system clock; all state on rising edge
- clr_n  in  1  asynchronous, active-low reset
- key  in  NKEY  raw coin buttons, active-low
- confirm_n  in  1  raw checkout button, active-low
- cmd  in  3  voice command level
- pay_bcd  out  4*DIGITS  paid total, BCD (digit 0 = LSBs)
- item_bcd  out  4*DIGITS  cart total, BCD
- change_bcd  out  4*DIGITS  pay − item, BCD
- item_sel  out  NITEM  sticky per-item "selected" flags
- pay_ovf, item_ovf  out  1  sticky saturation flags
- short  out  1  pay < item
- vend_en  out  1  dispenser servo enable
- busy  out  1  state ≠ SHOP

## Operation
- Debounce (per key and confirm): sync register; any level change reloads the counter to DEBOUNCE; the counter decrements to 0; at count 1 the level is committed. A committed 1→0 transition yields a one-cycle press pulse. Glitches shorter than DEBOUNCE produce no pulse.
- Coins (SHOP only): the sum of all COIN_VALS for keys pulsing in the same cycle is added to pay. If pay + sum > MAXVAL, pay holds and pay_ovf sets; pay_ovf clears only at checkout completion or reset.
- Commands (SHOP only), level-sensitive with an arm flag:
  - cmd == ARM_CODE sets armed.
  - Armed and cmd in 1..NITEM: add PRICES[cmd−1] to item total (same saturation rule → item_ovf), set item_sel[cmd−1], clear armed.
  - Armed and cmd == 0: clear item total, item_sel and item_ovf; clear armed.
  - Armed and any other code: ignored; armed stays set.
  - Repeated codes without re-arming are ignored.
- Derived: short = (pay < item). change = pay − item when !short. change_bcd is all-F when short or either ovf is set. pay_bcd / item_bcd are all-F while the respective ovf is set.
- FSM:
  - SHOP→VEND on confirm pulse when item > 0, !short, !pay_ovf, !item_ovf; otherwise the pulse is ignored.
  - VEND: vend_en = 1 for exactly VEND_CYCLES, then →CHANGE.
  - CHANGE: all values frozen for HOLD_CYCLES. On exit, pay, item, item_sel, ovf flags and armed are cleared; →SHOP.
  - In VEND/CHANGE, coin, confirm and cmd inputs are discarded. Debouncers keep running.

## Timing
- Reset values: all BCD outputs 0, item_sel 0, pay_ovf 0, item_ovf 0, short 0, vend_en 0, busy 0, state SHOP, armed 0, debounced levels 1, counters 0.
- Reset asserted mid-VEND: vend_en drops asynchronously.
- Press pulse occurs DEBOUNCE+1 edges after the edge that first samples the new stable level. The total register updates on the following edge; BCD outputs, short and change are registered one edge later.
- Command effect: total updates on the first edge at which armed and the select code coexist. BCD follows one edge later.
- vend_en rises on the edge after the confirm pulse and is high for VEND_CYCLES cycles. Totals read 0 on the BCD outputs one edge after CHANGE exits.

## Test plan
- Reset: hold clr_n low with random inputs → all outputs 0. Release → still 0 with idle inputs.
- Coins: two clean key[0] presses and one key[1] press → pay_bcd 0x11. A 3-cycle low glitch on key[1] → no change. key[0] and key[1] pressed simultaneously → +6 in one update.
- Commands: cmd 7→2→0(unarmed)→2 → item_bcd 0x05, item_sel 4'b0010, change_bcd 0x06. Then 7→0 → item_bcd 0x00, item_sel 0.
- Short: pay 1, select code 4 (price 10) → short 1, change_bcd 0xFF. Confirm press → busy stays 0.
- Checkout: pay 11, item 5, confirm → vend_en high exactly 16 cycles, change_bcd 0x06 held 32 cycles. Coin presses during this window are ignored. Afterwards pay/item/change 0x00 and item_sel 0.
- Saturation/reset: 20× key[0] → pay stops at 95; the 20th press sets pay_ovf, pay_bcd 0xFF, and confirm is refused. Assert clr_n mid-VEND → vend_en 0 immediately, all outputs return to reset values.

Source files
------------

// File: rtl/vend_checkout_core.sv
// Vending checkout controller: debounced coin/confirm keys, saturating pay and cart totals,
// armed voice-command item selection, SHOP/VEND/CHANGE sequencing and packed BCD outputs.
module vend_checkout_core #(
    parameter int               NKEY        = 2,
    parameter logic [8*NKEY-1:0]  COIN_VALS = {8'd1, 8'd5},
    parameter int               NITEM       = 4,
    parameter logic [8*NITEM-1:0] PRICES    = {8'd10, 8'd8, 8'd5, 8'd3},
    parameter int               DIGITS      = 2,
    parameter int               DEBOUNCE    = 8,
    parameter int               VEND_CYCLES = 16,
    parameter int               HOLD_CYCLES = 32,
    parameter logic [2:0]       ARM_CODE    = 3'b111
) (
    input  logic                  clock,
    input  logic                  clr_n,
    input  logic [NKEY-1:0]       key,
    input  logic                  confirm_n,
    input  logic [2:0]            cmd,
    output logic [4*DIGITS-1:0]   pay_bcd,
    output logic [4*DIGITS-1:0]   item_bcd,
    output logic [4*DIGITS-1:0]   change_bcd,
    output logic [NITEM-1:0]      item_sel,
    output logic                  pay_ovf,
    output logic                  item_ovf,
    output logic                  short,
    output logic                  vend_en,
    output logic                  busy
);

    localparam int MAXVAL = 10**DIGITS - 1;
    localparam int TW     = $clog2(MAXVAL + 1);
    localparam int SW     = TW + 12;
    localparam int NCH    = NKEY + 1;
    localparam int CW     = $clog2(DEBOUNCE + 1);
    localparam int TMAX   = (VEND_CYCLES > HOLD_CYCLES) ? VEND_CYCLES : HOLD_CYCLES;
    localparam int TMW    = $clog2(TMAX + 1);

    typedef enum logic [1:0] {SHOP, VEND, CHANGE} state_t;

    // Returns {overflow, result}; on overflow the original value is kept.
    function automatic logic [TW:0] sat_add(input logic [TW-1:0] a, input logic [SW-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + b;
        if (s > SW'(MAXVAL)) sat_add = {1'b1, a};
        else                 sat_add = {1'b0, s[TW-1:0]};
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            to_bcd[4*d +: 4] = 4'(r % TW'(10));
            r = r / TW'(10);
        end
    endfunction

    logic [NCH-1:0] raw_n;
    logic [NCH-1:0] sync_q, sync_d, level_q, press_p0;
    logic [CW-1:0]  cnt_q [NCH];

    assign raw_n = {confirm_n, key};

    // Stage p0: per-channel debounce; a committed high-to-low level yields a one-cycle press
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            sync_q   <= '1;
            sync_d   <= '1;
            level_q  <= '1;
            press_p0 <= '0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            sync_q <= raw_n;
            sync_d <= sync_q;
            for (int i = 0; i < NCH; i++) begin
                press_p0[i] <= 1'b0;
                if (sync_q[i] != sync_d[i]) begin
                    cnt_q[i] <= CW'(DEBOUNCE);
                end else if (cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                    if (cnt_q[i] == CW'(1)) begin
                        level_q[i]  <= sync_d[i];
                        press_p0[i] <= level_q[i] & ~sync_d[i];
                    end
                end
            end
        end
    end

    logic [SW-1:0]    coin_sum;
    logic             coin_any, conf_p0;
    logic             cmd_item;
    logic [7:0]       cmd_price;
    logic [NITEM-1:0] cmd_onehot;

    always_comb begin
        coin_sum = '0;
        for (int i = 0; i < NKEY; i++)
            if (press_p0[i]) coin_sum = coin_sum + SW'(COIN_VALS[8*i +: 8]);
    end

    assign coin_any = |press_p0[NKEY-1:0];
    assign conf_p0  = press_p0[NKEY];

    always_comb begin
        cmd_item   = 1'b0;
        cmd_price  = '0;
        cmd_onehot = '0;
        for (int i = 0; i < NITEM; i++) begin
            if (cmd == 3'(i + 1)) begin
                cmd_item      = 1'b1;
                cmd_price     = PRICES[8*i +: 8];
                cmd_onehot[i] = 1'b1;
            end
        end
    end

    logic [TW-1:0]    pay_p1, item_p1;
    logic             pay_ovf_p1, item_ovf_p1, armed_q;
    logic [NITEM-1:0] sel_q;
    logic [TW:0]      pay_add, item_add;
    state_t           state_q, state_d;
    logic [TMW-1:0]   tmr_q, tmr_d;
    logic             done;

    assign pay_add  = sat_add(pay_p1, coin_sum);
    assign item_add = sat_add(item_p1, SW'(cmd_price));

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        done    = 1'b0;
        case (state_q)
            SHOP: begin
                if (conf_p0 && item_p1 != '0 && pay_p1 >= item_p1 && !pay_ovf_p1 && !item_ovf_p1) begin
                    state_d = VEND;
                    tmr_d   = TMW'(VEND_CYCLES - 1);
                end
            end
            VEND: begin
                if (tmr_q == '0) begin
                    state_d = CHANGE;
                    tmr_d   = TMW'(HOLD_CYCLES - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            CHANGE: begin
                if (tmr_q == '0) begin
                    state_d = SHOP;
                    done    = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = SHOP;
        endcase
    end

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= SHOP;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Stage p1: totals, sticky flags and command arming; only SHOP accepts input
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            pay_p1      <= '0;
            item_p1     <= '0;
            pay_ovf_p1  <= 1'b0;
            item_ovf_p1 <= 1'b0;
            sel_q       <= '0;
            armed_q     <= 1'b0;
        end else if (done) begin
            pay_p1      <= '0;
            item_p1     <= '0;
            pay_ovf_p1  <= 1'b0;
            item_ovf_p1 <= 1'b0;
            sel_q       <= '0;
            armed_q     <= 1'b0;
        end else if (state_q == SHOP) begin
            if (coin_any) begin
                if (pay_add[TW]) pay_ovf_p1 <= 1'b1;
                else             pay_p1     <= pay_add[TW-1:0];
            end
            if (cmd == ARM_CODE) begin
                armed_q <= 1'b1;
            end else if (armed_q) begin
                if (cmd == 3'd0) begin
                    item_p1     <= '0;
                    sel_q       <= '0;
                    item_ovf_p1 <= 1'b0;
                    armed_q     <= 1'b0;
                end else if (cmd_item) begin
                    if (item_add[TW]) item_ovf_p1 <= 1'b1;
                    else              item_p1     <= item_add[TW-1:0];
                    sel_q   <= sel_q | cmd_onehot;
                    armed_q <= 1'b0;
                end
            end
        end
    end

    logic [4*DIGITS-1:0] pay_bcd_p2, item_bcd_p2, change_bcd_p2;
    logic                short_p2;

    // Stage p2: registered display values and comparison
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            pay_bcd_p2    <= '0;
            item_bcd_p2   <= '0;
            change_bcd_p2 <= '0;
            short_p2      <= 1'b0;
        end else begin
            pay_bcd_p2  <= pay_ovf_p1  ? '1 : to_bcd(pay_p1);
            item_bcd_p2 <= item_ovf_p1 ? '1 : to_bcd(item_p1);
            short_p2    <= pay_p1 < item_p1;
            if (pay_p1 < item_p1 || pay_ovf_p1 || item_ovf_p1) change_bcd_p2 <= '1;
            else change_bcd_p2 <= to_bcd(pay_p1 - item_p1);
        end
    end

    assign pay_bcd    = pay_bcd_p2;
    assign item_bcd   = item_bcd_p2;
    assign change_bcd = change_bcd_p2;
    assign short      = short_p2;
    assign item_sel   = sel_q;
    assign pay_ovf    = pay_ovf_p1;
    assign item_ovf   = item_ovf_p1;
    assign vend_en    = (state_q == VEND);
    assign busy       = (state_q != SHOP);

endmodule

// File: tb/tb_vend_checkout_core.sv
// Directed and randomized bench for vend_checkout_core against an abstract shop model.
module tb_vend_checkout_core;

    localparam int D = 8;

    logic       clock = 1'b0;
    logic       clr_n;
    logic [1:0] key;
    logic       confirm_n;
    logic [2:0] cmd;
    logic [7:0] pay_bcd, item_bcd, change_bcd;
    logic [3:0] item_sel;
    logic       pay_ovf, item_ovf, short, vend_en, busy;

    vend_checkout_core dut (
        .clock(clock), .clr_n(clr_n), .key(key), .confirm_n(confirm_n), .cmd(cmd),
        .pay_bcd(pay_bcd), .item_bcd(item_bcd), .change_bcd(change_bcd),
        .item_sel(item_sel), .pay_ovf(pay_ovf), .item_ovf(item_ovf),
        .short(short), .vend_en(vend_en), .busy(busy)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Shop model: coin values by key, prices by item code
    int coin_tab [2] = '{5, 1};
    int price_tab[4] = '{3, 5, 8, 10};
    int       m_pay, m_item;
    bit       m_povf, m_iovf, m_armed;
    logic [3:0] m_sel;

    function automatic logic [7:0] bcd2(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        m_pay = 0; m_item = 0; m_povf = 0; m_iovf = 0; m_armed = 0; m_sel = '0;
    endtask

    task automatic model_coins(input logic [1:0] mask);
        int s;
        s = 0;
        for (int i = 0; i < 2; i++) if (mask[i]) s += coin_tab[i];
        if (m_pay + s > 99) m_povf = 1;
        else m_pay += s;
    endtask

    task automatic model_cmd(input logic [2:0] c);
        if (c == 3'd7) m_armed = 1;
        else if (m_armed) begin
            if (c == 3'd0) begin
                m_item = 0; m_sel = '0; m_iovf = 0; m_armed = 0;
            end else if (c <= 3'd4) begin
                if (m_item + price_tab[c-1] > 99) m_iovf = 1;
                else m_item += price_tab[c-1];
                m_sel[c-1] = 1'b1;
                m_armed = 0;
            end
        end
    endtask

    task automatic check_all(input string t);
        bit sh;
        sh = m_pay < m_item;
        chk({t, ".pay_bcd"},  32'(pay_bcd),    32'(m_povf ? 8'hFF : bcd2(m_pay)));
        chk({t, ".item_bcd"}, 32'(item_bcd),   32'(m_iovf ? 8'hFF : bcd2(m_item)));
        chk({t, ".short"},    32'(short),      32'(sh));
        chk({t, ".change"},   32'(change_bcd), 32'((sh || m_povf || m_iovf) ? 8'hFF : bcd2(m_pay - m_item)));
        chk({t, ".item_sel"}, 32'(item_sel),   32'(m_sel));
        chk({t, ".pay_ovf"},  32'(pay_ovf),    32'(m_povf));
        chk({t, ".item_ovf"}, 32'(item_ovf),   32'(m_iovf));
        chk({t, ".busy"},     32'(busy),       32'd0);
        chk({t, ".vend_en"},  32'(vend_en),    32'd0);
    endtask

    task automatic press(input logic [1:0] mask);
        key = ~mask;
        tick(D + 4);
        key = 2'b11;
        tick(D + 4);
        model_coins(mask);
    endtask

    task automatic set_cmd(input logic [2:0] c);
        cmd = c;
        tick(3);
        model_cmd(c);
    endtask

    task automatic press_confirm();
        confirm_n = 1'b0;
        tick(D + 4);
        confirm_n = 1'b1;
        tick(D + 4);
    endtask

    task automatic do_reset();
        key = 2'b11; confirm_n = 1'b1; cmd = 3'd0;
        clr_n = 1'b0;
        tick(2);
        clr_n = 1'b1;
        tick(2);
        model_clear();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  vcnt, hcnt, waited;
        bit  chg_ok, started, seen;
        logic [2:0] rc;

        // Reset with random inputs
        model_clear();
        clr_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            key = 2'($urandom); confirm_n = 1'($urandom); cmd = 3'($urandom);
            tick(1);
        end
        check_all("reset_held");
        key = 2'b11; confirm_n = 1'b1; cmd = 3'd0;
        tick(1);
        clr_n = 1'b1;
        tick(D + 6);
        check_all("reset_released");

        // Coins, glitch rejection
        press(2'b01); press(2'b01); press(2'b10);
        chk("coins_11", 32'(pay_bcd), 32'h11);
        check_all("coins");
        key = 2'b01;
        tick($urandom_range(1, D - 2));
        key = 2'b11;
        tick(2 * D + 4);
        chk("glitch_pay", 32'(pay_bcd), 32'h11);
        check_all("glitch");

        // Commands: unarmed repeat ignored, then armed clear
        set_cmd(3'd7); set_cmd(3'd2); set_cmd(3'd0); set_cmd(3'd2);
        chk("cmd_item", 32'(item_bcd), 32'h05);
        chk("cmd_sel", 32'(item_sel), 32'h2);
        chk("cmd_change", 32'(change_bcd), 32'h06);
        check_all("cmd_select");
        set_cmd(3'd7); set_cmd(3'd0);
        chk("cmd_clear_item", 32'(item_bcd), 32'h00);
        chk("cmd_clear_sel", 32'(item_sel), 32'h0);
        check_all("cmd_clear");

        press(2'b11);
        chk("coins_simul", 32'(pay_bcd), 32'h17);
        check_all("simul");

        // Short: pay 1, item 10, confirm refused
        do_reset();
        press(2'b10);
        set_cmd(3'd7); set_cmd(3'd4);
        chk("short_flag", 32'(short), 32'd1);
        chk("short_change", 32'(change_bcd), 32'hFF);
        press_confirm();
        check_all("short_refused");

        // Checkout with ignored coin press during the busy window
        do_reset();
        press(2'b01); press(2'b01); press(2'b10);
        set_cmd(3'd7); set_cmd(3'd2);
        check_all("pre_checkout");
        vcnt = 0; hcnt = 0; chg_ok = 1; started = 0;
        confirm_n = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick(1);
            if (c == 12) confirm_n = 1'b1;
            if (c == 20) key = 2'b10;
            if (c == 20 + D + 4) key = 2'b11;
            if (vend_en) vcnt++;
            else if (busy) begin
                hcnt++;
                if (change_bcd !== 8'h06) chg_ok = 0;
            end
            if (busy) started = 1;
            if (started && !busy) break;
        end
        chk("checkout_done", 32'(started && !busy), 32'd1);
        chk("vend_cycles", 32'(vcnt), 32'd16);
        chk("hold_cycles", 32'(hcnt), 32'd32);
        chk("hold_change", 32'(chg_ok), 32'd1);
        tick(2);
        model_clear();
        check_all("post_checkout");

        // Saturation
        for (int i = 0; i < 19; i++) press(2'b01);
        chk("sat_95", 32'(pay_bcd), 32'h95);
        press(2'b01);
        chk("sat_ovf", 32'(pay_ovf), 32'd1);
        chk("sat_bcd", 32'(pay_bcd), 32'hFF);
        set_cmd(3'd7); set_cmd(3'd1);
        press_confirm();
        check_all("sat_refused");

        // Reset mid-VEND
        do_reset();
        press(2'b01); press(2'b01); press(2'b10);
        set_cmd(3'd7); set_cmd(3'd2);
        confirm_n = 1'b0;
        seen = 0;
        waited = 0;
        while (!seen && waited < 100) begin
            tick(1);
            waited++;
            if (vend_en) seen = 1;
        end
        chk("vend_started", 32'(seen), 32'd1);
        tick(3);
        #2 clr_n = 1'b0;
        #1 chk("async_vend_drop", 32'(vend_en), 32'd0);
        model_clear();
        check_all("mid_vend_reset");
        confirm_n = 1'b1; cmd = 3'd0;
        tick(2);
        clr_n = 1'b1;
        tick(D + 6);
        check_all("after_mid_reset");

        // Randomized coin/command traffic against the model
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: press(2'($urandom_range(1, 3)));
                1: begin
                    rc = 3'($urandom_range(0, 7));
                    set_cmd(rc);
                end
                default: begin
                    set_cmd(3'd7);
                    rc = 3'($urandom_range(0, 5));
                    set_cmd(rc);
                end
            endcase
            check_all("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
